id_ex_stage: RTL and testbench

- ID/EX pipeline stage for the 5-stage RV pipeline. It sits directly downstream of the opcode control decoder.
- Each cycle it registers the decoder's 8-bit control word {Ex[2:0], Mem[2:0], Wb[1:0]} together with ID-stage operands and register addresses.
- It detects load-use hazards (combinational hazard detection, registered bubble insertion) and supports stall and flush from the branch/hazard logic.
- It presents decoded, individually named control bits to EX.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the RV pipeline blocks.
//   - Control-word layout {ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
//   - Major opcode constants used by the control decoder
//   - Default datapath / register-address widths
package cpu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  localparam int CTRL_W        = 8;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;

  typedef enum logic [6:0] {
    OPC_RTYPE  = 7'b0110011,
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  // An all-zero control word carries no architectural effect.
  function automatic logic ctrl_is_nop(input logic [CTRL_W-1:0] ctrl);
    return ctrl == CTRL_NOP;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: purely combinational load-use hazard compare.
//   ex_mem_read_i  - instruction in EX is a load
//   ex_valid_i     - EX slot holds a real instruction
//   ex_rd_addr_i   - destination register of the EX instruction
//   id_rs1_addr_i, id_rs2_addr_i - source registers of the ID instruction
//   hazard_o       - ID instruction consumes a value the EX load has not produced yet
module load_use_detect #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_mem_read_i,
  input  logic               ex_valid_i,
  input  logic [RADDR_W-1:0] ex_rd_addr_i,
  input  logic [RADDR_W-1:0] id_rs1_addr_i,
  input  logic [RADDR_W-1:0] id_rs2_addr_i,
  output logic               hazard_o
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_mem_read_i & ex_valid_i & (ex_rd_addr_i != '0) &
                    ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
//   Inputs : clk_i, rst_i (sync, active-high), ctrl_i (decoder control word),
//            stall_i (hold), flush_i (branch-taken bubble), ID pc/operands/imm,
//            funct_i {funct7,funct3}, rs1/rs2/rd addresses.
//   Outputs: individually decoded control bits, registered pc/operands/imm/funct/
//            addresses, valid_o (EX slot is real), hazard_o (combinational
//            load-use detect for PC / IF-ID write enables).
//   Optional: define ID_EX_PERF_CNT_EN to add bubble_cnt_o[31:0], counting
//            edges at which a bubble is inserted by flush_i or hazard_o.
// Next-state priority: rst_i > flush_i > hazard_o > stall_i > load.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [9:0]         funct_i,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  output logic [1:0]         alu_op_o,
  output logic               alu_src_o,
  output logic               branch_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [9:0]         funct_o,
  output logic [RADDR_W-1:0] rs1_addr_o,
  output logic [RADDR_W-1:0] rs2_addr_o,
  output logic [RADDR_W-1:0] rd_addr_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        bubble_cnt_o,
`endif
  output logic               valid_o,
  output logic               hazard_o
);

  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [9:0]         funct_q, funct_d;
  logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic               hazard;
  logic               bubble;

  load_use_detect #(.RADDR_W(RADDR_W)) u_load_use_detect (
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_valid_i    (valid_q),
    .ex_rd_addr_i  (rd_addr_q),
    .id_rs1_addr_i (rs1_addr_i),
    .id_rs2_addr_i (rs2_addr_i),
    .hazard_o      (hazard)
  );

  // A hazard bubble must win over stall: holding would re-present the load
  // to EX and let the dependent instruction slip in behind it twice.
  assign bubble = flush_i | hazard;

  always_comb begin
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    if (bubble || !stall_i) begin
      // Data fields load on a bubble as well; they are ignored with valid_o low.
      pc_d       = pc_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      funct_d    = funct_i;
      rs1_addr_d = rs1_addr_i;
      rs2_addr_d = rs2_addr_i;
      rd_addr_d  = rd_addr_i;
      if (bubble) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = ctrl_i;
        valid_d = !ctrl_is_nop(ctrl_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Wraps naturally modulo 2^32; a pure stall inserts no bubble so it holds.
  assign bubble_cnt_d = bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

  assign alu_op_o     = ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign alu_src_o    = ctrl_q[CTRL_ALUSRC];
  assign branch_o     = ctrl_q[CTRL_BRANCH];
  assign mem_read_o   = ctrl_q[CTRL_MEMREAD];
  assign mem_write_o  = ctrl_q[CTRL_MEMWRITE];
  assign reg_write_o  = ctrl_q[CTRL_REGWRITE];
  assign mem_to_reg_o = ctrl_q[CTRL_MEMTOREG];
  assign valid_o      = valid_q;
  assign hazard_o     = hazard;
  assign pc_o         = pc_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign funct_o      = funct_q;
  assign rs1_addr_o   = rs1_addr_q;
  assign rs2_addr_o   = rs2_addr_q;
  assign rd_addr_o    = rd_addr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage.
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// following edge (registered) or after settling (combinational hazard_o).
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [7:0]  ctrl_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [1:0]  alu_op_o;
  logic        alu_src_o, branch_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        valid_o, hazard_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif
  logic [7:0]  ctrl_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign ctrl_out = {alu_op_o, alu_src_o, branch_o, mem_read_o, mem_write_o,
                     reg_write_o, mem_to_reg_o};

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .funct_o(funct_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .valid_o(valid_o), .hazard_o(hazard_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ctrl_i     = c;
    pc_i       = pc;
    rs1_addr_i = rs1;
    rs2_addr_i = rs2;
    rd_addr_i  = rd;
    rs1_data_i = pc + 32'h1000;
    rs2_data_i = pc + 32'h2000;
    imm_i      = pc + 32'h3000;
    funct_i    = pc[9:0];
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(8'h0B, 32'h40, 5'd0, 5'd0, 5'd0);

    // Reset for two edges
    step(); step();
    check("rst_ctrl", {24'h0, ctrl_out}, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_imm", imm_o, 32'h0);
    check("rst_rd", {27'h0, rd_addr_o}, 32'h0);

    // First edge after release loads the held inputs
    rst_i = 1'b0;
    step();
    check("load_pc", pc_o, 32'h40);
    check("load_ctrl", {24'h0, ctrl_out}, 32'h0B);
    check("load_valid", {31'h0, valid_o}, 32'h1);

    // R-type pass-through
    drive(8'h82, 32'h44, 5'd1, 5'd2, 5'd5);
    step();
    check("rtype_aluop", {30'h0, alu_op_o}, 32'h2);
    check("rtype_regwr", {31'h0, reg_write_o}, 32'h1);
    check("rtype_alusrc", {31'h0, alu_src_o}, 32'h0);
    check("rtype_valid", {31'h0, valid_o}, 32'h1);
    check("rtype_rd", {27'h0, rd_addr_o}, 32'h5);
    check("rtype_rs1d", rs1_data_o, 32'h1044);
    check("rtype_funct", {22'h0, funct_o}, 32'h044);

    // Load-use: lw x7 then add using x7 as rs2
    drive(8'h2B, 32'h48, 5'd3, 5'd4, 5'd7);
    check("lw_id_hazard", {31'h0, hazard_o}, 32'h0);
    step();
    drive(8'h82, 32'h4C, 5'd6, 5'd7, 5'd8);
    check("lu_hazard", {31'h0, hazard_o}, 32'h1);
    step();
    check("lu_bubble_ctrl", {24'h0, ctrl_out}, 32'h0);
    check("lu_bubble_valid", {31'h0, valid_o}, 32'h0);
    check("lu_hazard_drop", {31'h0, hazard_o}, 32'h0);
    step();
    check("lu_add_ctrl", {24'h0, ctrl_out}, 32'h82);
    check("lu_add_valid", {31'h0, valid_o}, 32'h1);
    check("lu_add_rd", {27'h0, rd_addr_o}, 32'h8);

    // Load into x0: no hazard
    drive(8'h2B, 32'h50, 5'd3, 5'd4, 5'd0);
    step();
    drive(8'h82, 32'h54, 5'd0, 5'd0, 5'd9);
    check("x0_no_hazard", {31'h0, hazard_o}, 32'h0);
    step();
    check("x0_add_ctrl", {24'h0, ctrl_out}, 32'h82);
    check("x0_add_rd", {27'h0, rd_addr_o}, 32'h9);

    // Stall: three cycles of changing inputs, outputs frozen
    drive(8'h82, 32'h100, 5'd1, 5'd2, 5'd10);
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'h25, 32'h200 + i, 5'd3, 5'd4, 5'(11 + i));
      step();
      check("stall_pc", pc_o, 32'h100);
      check("stall_ctrl", {24'h0, ctrl_out}, 32'h82);
      check("stall_rd", {27'h0, rd_addr_o}, 32'hA);
    end
    stall_i = 1'b0;

    // Stall together with load-use: bubble wins, then stall holds the bubble
    drive(8'h2B, 32'h300, 5'd1, 5'd2, 5'd12);
    step();
    stall_i = 1'b1;
    drive(8'h82, 32'h304, 5'd12, 5'd2, 5'd13);
    check("st_hazard", {31'h0, hazard_o}, 32'h1);
    step();
    check("st_bubble_ctrl", {24'h0, ctrl_out}, 32'h0);
    check("st_bubble_valid", {31'h0, valid_o}, 32'h0);
    step();
    check("st_hold_bubble", {31'h0, valid_o}, 32'h0);
    stall_i = 1'b0;
    step();
    check("st_add_ctrl", {24'h0, ctrl_out}, 32'h82);
    check("st_add_pc", pc_o, 32'h304);

    // Flush: beq in EX, sd in ID is squashed
    drive(8'h50, 32'h400, 5'd1, 5'd2, 5'd0);
    step();
    check("beq_branch", {31'h0, branch_o}, 32'h1);
    check("beq_aluop", {30'h0, alu_op_o}, 32'h1);
    flush_i = 1'b1;
    drive(8'h25, 32'h404, 5'd1, 5'd2, 5'd0);
    step();
    check("flush_memwr", {31'h0, mem_write_o}, 32'h0);
    check("flush_valid", {31'h0, valid_o}, 32'h0);
    check("flush_pc", pc_o, 32'h404);
    flush_i = 1'b0;
    step();
    check("sd_memwr", {31'h0, mem_write_o}, 32'h1);
    check("sd_valid", {31'h0, valid_o}, 32'h1);

    // Flush together with stall: bubble, data loads
    flush_i = 1'b1; stall_i = 1'b1;
    drive(8'h82, 32'h500, 5'd1, 5'd2, 5'd14);
    step();
    check("fs_ctrl", {24'h0, ctrl_out}, 32'h0);
    check("fs_valid", {31'h0, valid_o}, 32'h0);
    check("fs_pc", pc_o, 32'h500);
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    check("fs_after_ctrl", {24'h0, ctrl_out}, 32'h82);

`ifdef ID_EX_PERF_CNT_EN
    // Two hazard bubbles and two flush bubbles so far
    check("bubble_cnt", bubble_cnt_o, 32'd4);
`endif

    // Reset mid-stall clears everything
    stall_i = 1'b1; rst_i = 1'b1;
    step();
    check("rst2_ctrl", {24'h0, ctrl_out}, 32'h0);
    check("rst2_valid", {31'h0, valid_o}, 32'h0);
    check("rst2_pc", pc_o, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
    check("rst2_bubble_cnt", bubble_cnt_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
